// File: rtl/mcpu_gpu_console.sv
// ============================================================================
// Module   : mcpu_gpu_console
// Brief    : Byte-stream text console writer driving the mcpu_gpu VRAM port;
//            tracks a 32x32 cursor, handles LF/CR/BS/FF, scrolls and clears.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mcpu_gpu_console #(
    parameter logic [7:0] FILL_CHAR = 8'h20,
    parameter bit         SCROLL_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  char_in,
    input  logic        char_valid,
    output logic        char_ready,
    input  logic [2:0]  page,
    output logic [12:0] vram_addr,
    output logic        vram_re,
    output logic        vram_we,
    inout  wire  [7:0]  data_bus,
    output logic [4:0]  cursor_col,
    output logic [4:0]  cursor_row,
    output logic        busy
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_PUT    = 3'd1;
    localparam logic [2:0] S_SCR_RD = 3'd2;
    localparam logic [2:0] S_SCR_WR = 3'd3;
    localparam logic [2:0] S_FILL   = 3'd4;
    localparam logic [2:0] S_CLR    = 3'd5;

    localparam logic [7:0] c_LF = 8'h0A;
    localparam logic [7:0] c_CR = 8'h0D;
    localparam logic [7:0] c_BS = 8'h08;
    localparam logic [7:0] c_FF = 8'h0C;
    localparam logic [4:0] c_LAST = 5'd31;
    localparam logic [9:0] c_IDX_LAST = 10'd1023;

    logic [2:0]  r_state, w_state;
    logic [4:0]  r_col, w_col;
    logic [4:0]  r_row, w_row;
    logic [2:0]  r_page, w_page;
    logic [7:0]  r_char, w_char;
    logic        r_noadv, w_noadv;
    logic [9:0]  r_idx, w_idx;
    logic [7:0]  r_rdata, w_rdata;
    logic [12:0] r_addr_hold, w_addr;
    logic        w_we_raw;
    logic [7:0]  w_wdata;
    logic        w_prot;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_col       <= '0;
            r_row       <= '0;
            r_page      <= '0;
            r_char      <= '0;
            r_noadv     <= 1'b0;
            r_idx       <= '0;
            r_rdata     <= '0;
            r_addr_hold <= '0;
        end else begin
            r_state     <= w_state;
            r_col       <= w_col;
            r_row       <= w_row;
            r_page      <= w_page;
            r_char      <= w_char;
            r_noadv     <= w_noadv;
            r_idx       <= w_idx;
            r_rdata     <= w_rdata;
            r_addr_hold <= w_addr;
        end
    end

    always_comb begin
        w_state  = r_state;
        w_col    = r_col;
        w_row    = r_row;
        w_page   = r_page;
        w_char   = r_char;
        w_noadv  = r_noadv;
        w_idx    = r_idx;
        w_rdata  = r_rdata;
        w_addr   = r_addr_hold;
        w_we_raw = 1'b0;
        w_wdata  = FILL_CHAR;
        vram_re  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (char_valid) begin
                    w_page  = page;
                    w_char  = char_in;
                    w_noadv = 1'b0;
                    case (char_in)
                        c_LF: begin
                            if (r_row == c_LAST) begin
                                if (SCROLL_EN) begin
                                    w_state = S_SCR_RD;
                                    w_idx   = 10'd32;
                                end else begin
                                    w_row = '0;
                                end
                            end else begin
                                w_row = r_row + 5'd1;
                            end
                        end
                        c_CR: w_col = '0;
                        c_BS: begin
                            if (r_col != 5'd0) begin
                                w_col   = r_col - 5'd1;
                                w_char  = FILL_CHAR;
                                w_noadv = 1'b1;
                                w_state = S_PUT;
                            end
                        end
                        c_FF: begin
                            w_state = S_CLR;
                            w_idx   = '0;
                        end
                        default: w_state = S_PUT;
                    endcase
                end
            end
            S_PUT: begin
                w_addr   = {r_page, r_row, r_col};
                w_we_raw = 1'b1;
                w_wdata  = r_char;
                w_state  = S_IDLE;
                if (!r_noadv) begin
                    if (r_col == c_LAST) begin
                        w_col = '0;
                        if (r_row == c_LAST) begin
                            if (SCROLL_EN) begin
                                w_state = S_SCR_RD;
                                w_idx   = 10'd32;
                            end else begin
                                w_row = '0;
                            end
                        end else begin
                            w_row = r_row + 5'd1;
                        end
                    end else begin
                        w_col = r_col + 5'd1;
                    end
                end
            end
            S_SCR_RD: begin
                w_addr  = {r_page, r_idx};
                vram_re = 1'b1;
                w_rdata = data_bus;
                w_state = S_SCR_WR;
            end
            S_SCR_WR: begin
                w_addr   = {r_page, r_idx - 10'd32};
                w_we_raw = 1'b1;
                w_wdata  = r_rdata;
                if (r_idx == c_IDX_LAST) begin
                    w_state = S_FILL;
                    w_idx   = 10'd992;
                end else begin
                    w_state = S_SCR_RD;
                    w_idx   = r_idx + 10'd1;
                end
            end
            S_FILL, S_CLR: begin
                w_addr   = {r_page, r_idx};
                w_we_raw = 1'b1;
                if (r_idx == c_IDX_LAST) begin
                    w_state = S_IDLE;
                    w_col   = '0;
                    w_row   = (r_state == S_FILL) ? c_LAST : 5'd0;
                end else begin
                    w_idx = r_idx + 10'd1;
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    // The last four words of page 7 are GPU control registers: never written.
    assign w_prot     = &w_addr[12:2];
    assign vram_we    = w_we_raw & ~w_prot;
    assign vram_addr  = w_addr;
    assign data_bus   = vram_we ? w_wdata : 8'hzz;
    assign char_ready = (r_state == S_IDLE);
    assign busy       = ~char_ready;
    assign cursor_col = r_col;
    assign cursor_row = r_row;

endmodule

`default_nettype wire
